// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//
// Shares one external combinational WIDTH x WIDTH multiplier among NUM_REQ
// requesters. Requesters are granted round-robin through a valid/ready
// handshake. The granted operands are registered onto the multiplier inputs.
// After MULT_LAT cycles the product is captured and returned, with the
// requester index, through a valid/ready response port.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   req_valid/req_ready  per-requester handshake (at most one ready bit high)
//   req_a, req_b         packed operands; requester i uses [i*WIDTH +: WIDTH]
//   mult_a, mult_b       registered operands driven to the shared multiplier
//   mult_y               product returned by the shared multiplier
//   rsp_valid/rsp_ready  response handshake
//   rsp_id, rsp_y        owning requester index and captured product
//   busy                 high while an operation is in flight (COMPUTE/RESP)
//   op_count             completed responses, wraps at 16 bits

module mult_share_arbiter #(
  parameter int WIDTH    = 8,
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int MULT_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         mult_a,
  output logic [WIDTH-1:0]         mult_b,
  input  logic [2*WIDTH-1:0]       mult_y,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]       rsp_y,
  output logic                     busy,
  output logic [15:0]              op_count
);

  // The counter only has to hold MULT_LAT-1; keep at least one bit.
  localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     mult_a_q, mult_a_d;
  logic [WIDTH-1:0]     mult_b_q, mult_b_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic [2*WIDTH-1:0]   rsp_y_q, rsp_y_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [15:0]          op_count_q, op_count_d;

  logic                 gnt_found;
  logic [ID_W-1:0]      gnt_idx;
  logic [ID_W-1:0]      gnt_next;
  logic [ID_W:0]        cand;

  // Round-robin search starting at rr_ptr. The candidate index is computed
  // one bit wider so the wrap also works when NUM_REQ is not a power of two.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[ID_W-1:0];
      end
    end
    if (gnt_idx == ID_W'(NUM_REQ - 1)) begin
      gnt_next = '0;
    end else begin
      gnt_next = gnt_idx + ID_W'(1);
    end
  end

  // Next-state and datapath logic. req_ready is asserted only in IDLE and
  // depends only on state, rr_ptr and req_valid, so the chosen requester is
  // always accepted in the same cycle.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    mult_a_d    = mult_a_q;
    mult_b_d    = mult_b_q;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    rsp_valid_d = rsp_valid_q;
    op_count_d  = op_count_q;
    req_ready   = '0;

    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          mult_a_d           = req_a[gnt_idx*WIDTH +: WIDTH];
          mult_b_d           = req_b[gnt_idx*WIDTH +: WIDTH];
          rsp_id_d           = gnt_idx;
          rr_ptr_d           = gnt_next;
          cnt_d              = CNT_W'(MULT_LAT - 1);
          state_d            = COMPUTE;
        end
      end
      COMPUTE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rsp_y_d     = mult_y;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      mult_a_q    <= '0;
      mult_b_q    <= '0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
      rsp_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      mult_a_q    <= mult_a_d;
      mult_b_q    <= mult_b_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      rsp_valid_q <= rsp_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign mult_a    = mult_a_q;
  assign mult_b    = mult_b_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_valid = rsp_valid_q;
  assign op_count  = op_count_q;
  assign busy      = (state_q == COMPUTE) || (state_q == RESP);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter
//
// Directed bench for mult_share_arbiter. Two instances share clock and reset:
// dut1 with MULT_LAT=1 and dut3 with MULT_LAT=3. The shared multiplier is
// modelled as a plain combinational product of each instance's mult_a/mult_b.

module tb_mult_share_arbiter;

  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic clk;
  logic rst;

  logic [NUM_REQ-1:0]       reqValid1,  reqReady1;
  logic [NUM_REQ*WIDTH-1:0] reqA1,      reqB1;
  logic [WIDTH-1:0]         multA1,     multB1;
  logic [2*WIDTH-1:0]       multY1,     rspY1;
  logic                     rspValid1,  rspReady1, busy1;
  logic [ID_W-1:0]          rspId1;
  logic [15:0]              opCount1;

  logic [NUM_REQ-1:0]       reqValid3,  reqReady3;
  logic [NUM_REQ*WIDTH-1:0] reqA3,      reqB3;
  logic [WIDTH-1:0]         multA3,     multB3;
  logic [2*WIDTH-1:0]       multY3,     rspY3;
  logic                     rspValid3,  rspReady3, busy3;
  logic [ID_W-1:0]          rspId3;
  logic [15:0]              opCount3;

  int nChecks = 0;
  int nFails  = 0;

  // External multiplier models
  assign multY1 = {{WIDTH{1'b0}}, multA1} * {{WIDTH{1'b0}}, multB1};
  assign multY3 = {{WIDTH{1'b0}}, multA3} * {{WIDTH{1'b0}}, multB3};

  mult_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .MULT_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid1), .req_ready(reqReady1),
    .req_a(reqA1), .req_b(reqB1),
    .mult_a(multA1), .mult_b(multB1), .mult_y(multY1),
    .rsp_valid(rspValid1), .rsp_ready(rspReady1),
    .rsp_id(rspId1), .rsp_y(rspY1),
    .busy(busy1), .op_count(opCount1)
  );

  mult_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .MULT_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid3), .req_ready(reqReady3),
    .req_a(reqA3), .req_b(reqB3),
    .mult_a(multA3), .mult_b(multB3), .mult_y(multY3),
    .rsp_valid(rspValid3), .rsp_ready(rspReady3),
    .rsp_id(rspId3), .rsp_y(rspY3),
    .busy(busy3), .op_count(opCount3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle so outputs are sampled away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive dut1 request valids and response ready, then let the
  // combinational grant settle
  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic rspRdy);
    reqValid1 = valid;
    rspReady1 = rspRdy;
    #1;
  endtask

  task automatic setOperands(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    reqA1[idx*WIDTH +: WIDTH] = a;
    reqB1[idx*WIDTH +: WIDTH] = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] expReady;
    rst       = 1'b1;
    reqValid1 = '0; rspReady1 = 1'b1; reqA1 = '0; reqB1 = '0;
    reqValid3 = '0; rspReady3 = 1'b1; reqA3 = '0; reqB3 = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    checkOutput("rst_req_ready", 32'(reqReady1), 0);
    checkOutput("rst_mult_a",    32'(multA1),    0);
    checkOutput("rst_mult_b",    32'(multB1),    0);
    checkOutput("rst_rsp_valid", 32'(rspValid1), 0);
    checkOutput("rst_rsp_id",    32'(rspId1),    0);
    checkOutput("rst_rsp_y",     32'(rspY1),     0);
    checkOutput("rst_busy",      32'(busy1),     0);
    checkOutput("rst_op_count",  32'(opCount1),  0);

    // Single request 255 x 255 from requester 0
    $display("[TB] single request 255x255");
    setOperands(0, 8'd255, 8'd255);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("t1_req_ready", 32'(reqReady1), 32'b0001);
    step();
    applyStimulus(4'b0000, 1'b1);
    checkOutput("t1_busy",      32'(busy1),     1);
    checkOutput("t1_mult_a",    32'(multA1),    255);
    checkOutput("t1_mult_b",    32'(multB1),    255);
    checkOutput("t1_rsp_valid0",32'(rspValid1), 0);
    step();
    checkOutput("t1_rsp_valid", 32'(rspValid1), 1);
    checkOutput("t1_rsp_id",    32'(rspId1),    0);
    checkOutput("t1_rsp_y",     32'(rspY1),     65025);
    checkOutput("t1_op_count0", 32'(opCount1),  0);
    step();
    checkOutput("t1_rsp_done",  32'(rspValid1), 0);
    checkOutput("t1_op_count",  32'(opCount1),  1);
    checkOutput("t1_busy_done", 32'(busy1),     0);

    // All four requesters valid: order 0,1,2,3,0, one accept per 3 cycles
    $display("[TB] round robin over all requesters");
    doReset();
    for (int i = 0; i < NUM_REQ; i++) setOperands(i, 8'(i + 1), 8'd10);
    applyStimulus(4'b1111, 1'b1);
    for (int n = 0; n < 5; n++) begin
      int g;
      g = n % NUM_REQ;
      expReady = 4'b0001 << g;
      checkOutput($sformatf("t2_ready_%0d", n), 32'(reqReady1), 32'(expReady));
      step();
      checkOutput($sformatf("t2_mult_a_%0d", n), 32'(multA1), 32'(g + 1));
      checkOutput($sformatf("t2_cmp_ready_%0d", n), 32'(reqReady1), 0);
      step();
      checkOutput($sformatf("t2_rsp_valid_%0d", n), 32'(rspValid1), 1);
      checkOutput($sformatf("t2_rsp_id_%0d", n),    32'(rspId1),    32'(g));
      checkOutput($sformatf("t2_rsp_y_%0d", n),     32'(rspY1),     32'((g + 1) * 10));
      step();
    end
    applyStimulus(4'b0000, 1'b1);
    checkOutput("t2_op_count", 32'(opCount1), 5);

    // Only requesters 1 and 3 valid: grants alternate 1,3,1,3
    $display("[TB] alternating requesters 1 and 3");
    doReset();
    applyStimulus(4'b1010, 1'b1);
    for (int n = 0; n < 4; n++) begin
      expReady = (n % 2 == 0) ? 4'b0010 : 4'b1000;
      checkOutput($sformatf("t3_ready_%0d", n), 32'(reqReady1), 32'(expReady));
      step();
      checkOutput($sformatf("t3_rsp_id_pre_%0d", n), 32'(rspId1), (n % 2 == 0) ? 1 : 3);
      step();
      step();
    end
    applyStimulus(4'b0000, 1'b1);
    checkOutput("t3_op_count", 32'(opCount1), 4);

    // Requester 2, 128 x 128, with the response held off for 5 cycles
    $display("[TB] response backpressure");
    setOperands(2, 8'd128, 8'd128);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("t4_ready", 32'(reqReady1), 32'b0100);
    step();
    applyStimulus(4'b1111, 1'b0);
    step();
    for (int n = 0; n < 5; n++) begin
      checkOutput($sformatf("t4_rsp_valid_%0d", n), 32'(rspValid1), 1);
      checkOutput($sformatf("t4_rsp_y_%0d", n),     32'(rspY1),     16384);
      checkOutput($sformatf("t4_rsp_id_%0d", n),    32'(rspId1),    2);
      checkOutput($sformatf("t4_ready_%0d", n),     32'(reqReady1), 0);
      checkOutput($sformatf("t4_op_count_%0d", n),  32'(opCount1),  4);
      step();
    end
    applyStimulus(4'b0000, 1'b1);
    step();
    checkOutput("t4_rsp_done", 32'(rspValid1), 0);
    checkOutput("t4_op_count", 32'(opCount1),  5);

    // MULT_LAT=3 instance, 47 x 53
    $display("[TB] three-cycle latency instance");
    reqA3[7:0] = 8'd47;
    reqB3[7:0] = 8'd53;
    reqValid3  = 4'b0001;
    #1;
    checkOutput("t5_ready", 32'(reqReady3), 32'b0001);
    step();
    reqValid3 = 4'b0000;
    for (int n = 0; n < 3; n++) begin
      checkOutput($sformatf("t5_mult_a_%0d", n),    32'(multA3),    47);
      checkOutput($sformatf("t5_mult_b_%0d", n),    32'(multB3),    53);
      checkOutput($sformatf("t5_rsp_valid_%0d", n), 32'(rspValid3), 0);
      checkOutput($sformatf("t5_busy_%0d", n),      32'(busy3),     1);
      step();
    end
    checkOutput("t5_rsp_valid", 32'(rspValid3), 1);
    checkOutput("t5_rsp_y",     32'(rspY3),     2491);
    step();
    checkOutput("t5_op_count",  32'(opCount3),  1);

    // Reset during COMPUTE of a 200 x 200 request from requester 1
    $display("[TB] reset mid-operation");
    setOperands(1, 8'd200, 8'd200);
    applyStimulus(4'b0010, 1'b1);
    step();
    applyStimulus(4'b0000, 1'b1);
    checkOutput("t6_busy_pre",   32'(busy1),  1);
    checkOutput("t6_mult_a_pre", 32'(multA1), 200);
    doReset();
    checkOutput("t6_mult_a",    32'(multA1),    0);
    checkOutput("t6_mult_b",    32'(multB1),    0);
    checkOutput("t6_busy",      32'(busy1),     0);
    checkOutput("t6_rsp_valid", 32'(rspValid1), 0);
    checkOutput("t6_rsp_id",    32'(rspId1),    0);
    checkOutput("t6_rsp_y",     32'(rspY1),     0);
    checkOutput("t6_op_count",  32'(opCount1),  0);
    step();
    step();
    checkOutput("t6_no_rsp",    32'(rspValid1), 0);
    applyStimulus(4'b1111, 1'b1);
    checkOutput("t6_ready_from0", 32'(reqReady1), 32'b0001);
    applyStimulus(4'b0000, 1'b1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
